// File: rtl/div_unit_pkg.sv
// Shared decode constants and divider definitions: opcode/funct fields, state
// encodings, datapath width and the divide-by-zero quotient.
package div_unit_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;

  localparam int DIV_WIDTH = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
  localparam logic [5:0] DIV_LAST_STEP = 6'd31;

  typedef enum logic [1:0] {
    DIV_IDLE    = 2'b00,
    DIV_DIVZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  function automatic logic [DIV_WIDTH-1:0] neg_if(input logic neg,
                                                  input logic [DIV_WIDTH-1:0] val);
    return neg ? ((~val) + DIV_WIDTH'(1)) : val;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider for DIV/DIVU, one quotient bit per cycle,
// with pipeline stall request and annul support.
//
// state   | meaning
// IDLE    | waiting for start; operands latched on exit
// DIVZERO | divisor was zero, canned result loaded on exit
// ON      | 32 shift-subtract steps, counter 0..31
// END     | result valid, held while start stays high
module div_unit
  import div_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   signed_div,
  input  logic                   annul,
  input  logic [DIV_WIDTH-1:0]   opdata1,
  input  logic [DIV_WIDTH-1:0]   opdata2,
  output logic [2*DIV_WIDTH-1:0] result,
  output logic                   ready,
  output logic                   stall_req
);

  div_state_e state_q, state_d;
  logic [5:0]             cnt_q;
  logic                   sgn_q;
  logic                   neg1_q;
  logic                   neg2_q;
  logic [DIV_WIDTH-1:0]   dvd_q;
  logic [DIV_WIDTH-1:0]   dvs_q;
  logic [DIV_WIDTH-1:0]   rem_q;
  logic [2*DIV_WIDTH-1:0] result_q;

  logic                   accept;
  logic [DIV_WIDTH:0]     trial;
  logic [DIV_WIDTH:0]     diff;
  logic                   step_bit;
  logic [DIV_WIDTH-1:0]   step_rem;
  logic [DIV_WIDTH-1:0]   step_quot;
  logic [DIV_WIDTH-1:0]   quot_fix;
  logic [DIV_WIDTH-1:0]   rem_fix;

  assign accept = start && !annul;

  // Partial remainder is always below the divisor, so the 33-bit difference
  // only has bit 32 set when the trial subtraction borrows.
  always_comb begin
    trial     = {rem_q, dvd_q[DIV_WIDTH-1]};
    diff      = trial - {1'b0, dvs_q};
    step_bit  = ~diff[DIV_WIDTH];
    step_rem  = step_bit ? diff[DIV_WIDTH-1:0] : trial[DIV_WIDTH-1:0];
    step_quot = {dvd_q[DIV_WIDTH-2:0], step_bit};
    quot_fix  = neg_if(sgn_q & (neg1_q ^ neg2_q), step_quot);
    rem_fix   = neg_if(sgn_q & neg1_q, step_rem);
  end

  always_comb begin
    state_d   = state_q;
    stall_req = 1'b0;
    ready     = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (accept) begin
          stall_req = 1'b1;
          state_d   = (opdata2 == '0) ? DIV_DIVZERO : DIV_ON;
        end
      end
      DIV_DIVZERO: begin
        stall_req = 1'b1;
        state_d   = annul ? DIV_IDLE : DIV_END;
      end
      DIV_ON: begin
        stall_req = 1'b1;
        if (annul) begin
          state_d = DIV_IDLE;
        end else if (cnt_q == DIV_LAST_STEP) begin
          state_d = DIV_END;
        end
      end
      DIV_END: begin
        ready = !annul;
        if (annul || !start) begin
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  assign result = ready ? result_q : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (accept) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            sgn_q    <= signed_div;
            neg1_q   <= opdata1[DIV_WIDTH-1];
            neg2_q   <= opdata2[DIV_WIDTH-1];
            result_q <= '0;
            // Zero divisor keeps the raw dividend: it becomes the remainder.
            if (opdata2 == '0) begin
              dvd_q <= opdata1;
              dvs_q <= '0;
            end else begin
              dvd_q <= neg_if(signed_div & opdata1[DIV_WIDTH-1], opdata1);
              dvs_q <= neg_if(signed_div & opdata2[DIV_WIDTH-1], opdata2);
            end
          end
        end
        DIV_DIVZERO: begin
          result_q <= annul ? '0 : {dvd_q, DIV_ZERO_QUOT};
        end
        DIV_ON: begin
          if (annul) begin
            cnt_q    <= '0;
            result_q <= '0;
          end else begin
            dvd_q <= step_quot;
            rem_q <= step_rem;
            if (cnt_q == DIV_LAST_STEP) begin
              cnt_q    <= '0;
              result_q <= {rem_fix, quot_fix};
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end
        DIV_END: begin
          if (annul || !start) begin
            result_q <= '0;
          end
        end
        default: result_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed and random checks of div_unit: latency, results, stall, annul,
// reset, with a scoreboard of expected results.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic        annul = 1'b0;
  logic [31:0] opdata1 = '0;
  logic [31:0] opdata2 = '0;
  logic [63:0] result;
  logic        ready;
  logic        stall_req;

  int tests = 0;
  int fails = 0;
  logic [63:0] sb[$];

  div_unit dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .result     (result),
    .ready      (ready),
    .stall_req  (stall_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {r, q};
  endfunction

  // Entered 1 time unit after a rising edge. lat is the edge (relative to the
  // edge T0 that samples start) at which ready is first sampled high.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic [63:0] expv, input int exp_lat,
                        input int hold, input bit end_annul);
    int k;
    logic [63:0] held;
    sb.push_back(expv);
    opdata1    = a;
    opdata2    = b;
    signed_div = sgn;
    start      = 1'b1;
    #1;
    check($sformatf("%s_stall_idle", tag), 64'(stall_req), 64'd1);
    tick();
    opdata1    = ~a;
    opdata2    = b ^ 32'h5A5A_0001;
    signed_div = ~sgn;
    k = 0;
    while (ready !== 1'b1 && k < 40) begin
      check($sformatf("%s_stall_busy%0d", tag, k), 64'(stall_req), 64'd1);
      tick();
      k++;
    end
    check($sformatf("%s_latency", tag), 64'(k + 1), 64'(exp_lat));
    check($sformatf("%s_stall_end", tag), 64'(stall_req), 64'd0);
    held = sb.pop_front();
    check($sformatf("%s_result", tag), result, held);
    for (int h = 0; h < hold; h++) begin
      tick();
      check($sformatf("%s_hold_ready%0d", tag, h), 64'(ready), 64'd1);
      check($sformatf("%s_hold_result%0d", tag, h), result, held);
    end
    if (end_annul) begin
      annul = 1'b1;
      #1;
      check($sformatf("%s_annul_end_ready", tag), 64'(ready), 64'd0);
      check($sformatf("%s_annul_end_result", tag), result, 64'd0);
      tick();
      annul = 1'b0;
      start = 1'b0;
      #1;
      check($sformatf("%s_after_annul_ready", tag), 64'(ready), 64'd0);
      check($sformatf("%s_after_annul_stall", tag), 64'(stall_req), 64'd0);
    end else begin
      start = 1'b0;
      #1;
      check($sformatf("%s_drop_ready_same", tag), 64'(ready), 64'd1);
      tick();
      check($sformatf("%s_drop_ready", tag), 64'(ready), 64'd0);
      check($sformatf("%s_drop_result", tag), result, 64'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    #1;
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_stall", 64'(stall_req), 64'd0);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    do_div("u100_7", 32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 33, 0, 1'b0);
    do_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0, 1'b0);
    do_div("dz_s", 32'h1234_5678, 32'h0, 1'b1, {32'h1234_5678, 32'hFFFF_FFFF}, 2, 0, 1'b0);
    do_div("dz_u", 32'h1234_5678, 32'h0, 1'b0, {32'h1234_5678, 32'hFFFF_FFFF}, 2, 0, 1'b0);

    // Annul ten steps into the iteration.
    opdata1 = 32'd1000;
    opdata2 = 32'd3;
    signed_div = 1'b0;
    start = 1'b1;
    tick();
    repeat (10) begin
      check("annul_on_ready", 64'(ready), 64'd0);
      tick();
    end
    annul = 1'b1;
    #1;
    check("annul_on_stall_same", 64'(stall_req), 64'd1);
    tick();
    check("annul_stall_next", 64'(stall_req), 64'd0);
    check("annul_ready_next", 64'(ready), 64'd0);
    check("annul_result_next", result, 64'd0);
    annul = 1'b0;
    start = 1'b0;
    repeat (3) begin
      tick();
      check("annul_no_ready", 64'(ready), 64'd0);
    end

    do_div("u_ffff_10", 32'hFFFF_FFFF, 32'h10, 1'b0, {32'hF, 32'h0FFF_FFFF}, 33, 0, 1'b0);
    do_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 33, 5, 1'b0);

    // Reset pulse twenty steps into the iteration.
    opdata1 = 32'd100;
    opdata2 = 32'd7;
    signed_div = 1'b0;
    start = 1'b1;
    tick();
    repeat (20) tick();
    #2;
    resetn = 1'b0;
    #1;
    check("rst_mid_ready", 64'(ready), 64'd0);
    check("rst_mid_result", result, 64'd0);
    start = 1'b0;
    #1;
    check("rst_mid_stall", 64'(stall_req), 64'd0);
    repeat (3) begin
      tick();
      check("rst_hold_ready", 64'(ready), 64'd0);
    end
    #2;
    resetn = 1'b1;
    tick();
    do_div("after_rst", 32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 33, 0, 1'b0);

    do_div("annul_end", 32'd12345, 32'd67, 1'b0, ref_div(32'd12345, 32'd67, 1'b0), 33, 2, 1'b1);
    do_div("s_pos_neg", 32'd77, 32'hFFFF_FFF6, 1'b1, ref_div(32'd77, 32'hFFFF_FFF6, 1'b1), 33, 0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 2) rb = $urandom_range(1, 255);
      if (i == 4) rb = 32'h0;
      rs = i[0];
      do_div($sformatf("rand%0d", i), ra, rb, rs, ref_div(ra, rb, rs),
             (rb == 32'h0) ? 2 : 33, 0, 1'b0);
    end

    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port resetn, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port start, input, 1, division request from EX stage, issued for DIV/DIVU, held high until ready seen.
REQ-004 SHALL have port signed_div, input, 1: 1 = DIV (two's complement), 0 = DIVU.
REQ-005 SHALL have port annul, input, 1, pipeline flush/exception cancel.
REQ-006 SHALL have port opdata1, input, 32, dividend (rs).
REQ-007 SHALL have port opdata2, input, 32, divisor (rt).
REQ-008 SHALL have port result, output, 64: {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-009 SHALL have port ready, output, 1: result valid; qualifies HILO write.
REQ-010 SHALL have port stall_req, output, 1: freeze IF/ID/EX while division in progress.

Function
REQ-011 SHALL implement FSM states IDLE, DIVZERO, ON, END.
REQ-012 IDLE: start=1 and annul=0 -> DIVZERO if opdata2==0, else ON. Otherwise stay in IDLE.
REQ-013 On leaving IDLE, SHALL latch signed_div, sign bits, and operand magnitudes (absolute values when signed_div=1). Later operand changes SHALL be ignored.
REQ-014 ON: SHALL perform one restoring shift-subtract step per cycle, using a 6-bit counter 0..31. After step 31 -> END.
REQ-015 END: SHALL apply sign fixup. Quotient negated iff signed_div and operand signs differ. Remainder negated iff signed_div and dividend negative.
REQ-016 SHALL assert ready exactly 33 cycles after the edge sampling start (non-zero divisor). SHALL assert ready 2 cycles after that edge for a zero divisor.
REQ-017 ready and result SHALL hold stable in END while start=1. When start=0, SHALL go END -> IDLE with ready=0 on the next edge.
REQ-018 Divide-by-zero: SHALL produce quotient 32'hFFFFFFFF and remainder = opdata1 unmodified, for both signed and unsigned.
REQ-019 Signed 32'h80000000 / 32'hFFFFFFFF: SHALL produce quotient 32'h80000000 and remainder 0, with no trap.
REQ-020 stall_req SHALL be combinational and SHALL equal (state==ON or DIVZERO) or (state==IDLE and start and !annul). stall_req SHALL be 0 in END.
REQ-021 annul=1 in DIVZERO or ON: next edge -> IDLE, ready never asserted, result cleared to 0.
REQ-022 annul=1 in END: SHALL force ready=0 combinationally and return to IDLE on the next edge.
REQ-023 result SHALL be 0 whenever ready=0.

Reset
REQ-024 resetn=0 SHALL immediately force state IDLE, counter 0, internal dividend/divisor/partial-remainder registers 0, result 0, ready 0. stall_req follows REQ-020.
REQ-025 Reset mid-operation SHALL abandon the division with no ready pulse. The first start after resetn rises SHALL begin a fresh 33-cycle operation.

Structure
REQ-026 FSM state encodings (2-bit), DIV width 32, and the divide-by-zero quotient constant SHALL live in the shared defines.vh alongside the existing opcode/funct defines.
REQ-027 SHALL be a single module with no sub-module; the iteration datapath (33-bit subtract, shift) SHALL be inline.

Verification
REQ-028 Unsigned 100/7, start at edge T0 -> ready at T0+33, result = {32'h2, 32'hE}; stall_req high T0-1..T0+32.
REQ-029 Signed 0xFFFFFFF9 (-7) / 2 -> result = {32'hFFFFFFFF, 32'hFFFFFFFD}.
REQ-030 Divisor 0, dividend 0x12345678, signed and unsigned -> ready at T0+2, result = {32'h12345678, 32'hFFFFFFFF}.
REQ-031 annul at cycle 10 of ON -> no ready, stall_req low the next cycle. Following unsigned 0xFFFFFFFF/0x10 -> result = {32'hF, 32'h0FFFFFFF}.
REQ-032 Signed 0x80000000/0xFFFFFFFF -> result = {32'h0, 32'h80000000}. start held 5 extra cycles -> ready and result stable; start dropped -> ready 0 next cycle.
REQ-033 resetn pulsed low at cycle 20 of ON -> result 0 and ready 0 immediately, state IDLE. Next start completes normally.
